// File: rtl/fse_ctrl.sv
// Sequencing controller for the fractionally-spaced equalizer: derives the T/2,
// baud and tap-load strobes from one counter chain and runs the adaptation mode FSM.
module fse_ctrl #(
  parameter int CLK_PER_HALF = 4,
  parameter int NUM_TAPS     = 9,
  parameter int CMA_LEN      = 4096,
  parameter int UPD_DIV      = 1
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_force_dd,
  input  logic       i_freeze,
  output logic       o_en_rx,
  output logic       o_ctrl,
  output logic       o_baud,
  output logic       o_en_taps,
  output logic       o_mode,
  output logic [2:0] o_state
);

  localparam int HALF_W = (CLK_PER_HALF > 1) ? $clog2(CLK_PER_HALF) : 1;
  localparam int FILL_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int SYM_W  = (CMA_LEN > 1) ? $clog2(CMA_LEN) : 1;
  localparam int UPD_W  = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_PER_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_TAPS - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(CMA_LEN - 1);
  localparam logic [SYM_W-1:0]  SYM_ONE   = SYM_W'(1);
  localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPD_DIV - 1);
  localparam logic [UPD_W-1:0]  UPD_ONE   = UPD_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_CMA  = 3'd2,
    ST_DD   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [HALF_W-1:0] half_cnt_r;
  logic              phase_r;
  logic [FILL_W-1:0] fill_cnt_r;
  logic [SYM_W-1:0]  sym_cnt_r;
  logic [UPD_W-1:0]  upd_cnt_r;
  logic              saved_dd_r;
  logic              saved_dd_nxt_s;

  logic              wrap_s;
  logic              baud_s;
  logic              fill_done_s;
  logic              dd_cond_s;
  logic              run_nxt_s;
  logic              adapt_nxt_s;
  logic              tap_evt_s;
  logic              mode_nxt_s;

  assign o_state = state_r;

  // Strobe and transition conditions derived from the current counter chain.
  always_comb begin
    wrap_s      = (state_r != ST_IDLE) && (half_cnt_r == HALF_LAST);
    baud_s      = wrap_s && phase_r;
    fill_done_s = (state_r == ST_FILL) && wrap_s && (fill_cnt_r == FILL_LAST);
    dd_cond_s   = (state_r == ST_CMA) &&
                  (i_force_dd || (baud_s && (sym_cnt_r == SYM_LAST)));
  end

  // Next-state selection; a dropped enable overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (!i_enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_FILL;
        ST_FILL: begin
          if (fill_done_s) begin
            state_nxt_s = ST_CMA;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end
        ST_CMA: begin
          if (i_freeze) begin
            state_nxt_s = ST_HOLD;
          end else if (dd_cond_s) begin
            state_nxt_s = ST_DD;
          end else begin
            state_nxt_s = ST_CMA;
          end
        end
        ST_DD: begin
          if (i_freeze) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_DD;
          end
        end
        ST_HOLD: begin
          if (i_freeze) begin
            state_nxt_s = ST_HOLD;
          end else if (saved_dd_r) begin
            state_nxt_s = ST_DD;
          end else begin
            state_nxt_s = ST_CMA;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Saved mode and the registered-output qualifiers; strobes follow the state they appear in.
  always_comb begin
    saved_dd_nxt_s = saved_dd_r;
    if (state_nxt_s == ST_IDLE) begin
      saved_dd_nxt_s = 1'b0;
    end else if (((state_r == ST_CMA) || (state_r == ST_DD)) && (state_nxt_s == ST_HOLD)) begin
      // A CMA->DD condition coinciding with freeze makes HOLD resume in DD.
      saved_dd_nxt_s = (state_r == ST_DD) || dd_cond_s;
    end else begin
      saved_dd_nxt_s = saved_dd_r;
    end
    run_nxt_s   = (state_nxt_s != ST_IDLE);
    adapt_nxt_s = (state_nxt_s == ST_CMA) || (state_nxt_s == ST_DD);
    tap_evt_s   = baud_s && adapt_nxt_s;
    mode_nxt_s  = (state_nxt_s == ST_DD) || ((state_nxt_s == ST_HOLD) && saved_dd_nxt_s);
  end

  // Counter chain: half counter, phase bit, fill/symbol/update counters.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
      fill_cnt_r <= '0;
      sym_cnt_r  <= '0;
      upd_cnt_r  <= '0;
    end else if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE)) begin
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
      fill_cnt_r <= '0;
      sym_cnt_r  <= '0;
      upd_cnt_r  <= '0;
    end else begin
      if (wrap_s) begin
        half_cnt_r <= '0;
        phase_r    <= ~phase_r;
      end else begin
        half_cnt_r <= half_cnt_r + HALF_ONE;
      end
      if ((state_r == ST_FILL) && wrap_s) begin
        fill_cnt_r <= fill_done_s ? '0 : (fill_cnt_r + FILL_ONE);
      end
      // Only symbols that stay in CMA count; the terminal symbol leaves CMA instead.
      if (baud_s && (state_r == ST_CMA) && (state_nxt_s == ST_CMA)) begin
        sym_cnt_r <= sym_cnt_r + SYM_ONE;
      end
      if (tap_evt_s) begin
        upd_cnt_r <= (upd_cnt_r == UPD_LAST) ? '0 : (upd_cnt_r + UPD_ONE);
      end
    end
  end

  // State, saved mode and registered outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      saved_dd_r <= 1'b0;
      o_en_rx    <= 1'b0;
      o_ctrl     <= 1'b0;
      o_baud     <= 1'b0;
      o_en_taps  <= 1'b0;
      o_mode     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      saved_dd_r <= saved_dd_nxt_s;
      o_en_rx    <= run_nxt_s;
      o_ctrl     <= wrap_s && run_nxt_s;
      o_baud     <= baud_s && run_nxt_s;
      o_en_taps  <= tap_evt_s && (upd_cnt_r == UPD_LAST);
      o_mode     <= mode_nxt_s;
    end
  end

endmodule

// File: tb/tb_fse_ctrl.sv
// Directed bench for fse_ctrl: vector table for startup/mode steps plus
// multi-cycle sequences for CMA timeout, force-DD, freeze and disable/reset.
module tb_fse_ctrl;

  localparam int CPH = 4;
  localparam int NT  = 9;
  localparam int CL  = 16;
  localparam int UD  = 2;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_force_dd = 1'b0;
  logic       i_freeze = 1'b0;
  logic       o_en_rx, o_ctrl, o_baud, o_en_taps, o_mode;
  logic [2:0] o_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_ctrl = -1;
  int ctrl_idx = 0;
  int bench_upd = 0;

  fse_ctrl #(.CLK_PER_HALF(CPH), .NUM_TAPS(NT), .CMA_LEN(CL), .UPD_DIV(UD)) dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_force_dd(i_force_dd),
    .i_freeze(i_freeze), .o_en_rx(o_en_rx), .o_ctrl(o_ctrl), .o_baud(o_baud),
    .o_en_taps(o_en_taps), .o_mode(o_mode), .o_state(o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, fdd, frz;
    int   ncyc;
    logic ctrl, baud, taps, mode, en_rx;
    logic [2:0] st;
  } vec_t;

  function automatic vec_t mk(input logic rst, en, fdd, frz, input int ncyc,
                              input logic ctrl, baud, taps, mode, en_rx, input logic [2:0] st);
    vec_t v;
    v.rst = rst; v.en = en; v.fdd = fdd; v.frz = frz; v.ncyc = ncyc;
    v.ctrl = ctrl; v.baud = baud; v.taps = taps; v.mode = mode; v.en_rx = en_rx; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; sample 1 time unit after the edge and check strobe timing relations.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!o_en_rx) begin
      last_ctrl = -1;
      ctrl_idx  = 0;
      bench_upd = 0;
      if (o_ctrl || o_baud || o_en_taps || o_mode) chk("idle_strobe", 1, 0);
    end else if (last_ctrl < 0) begin
      last_ctrl = cyc;
    end
    if (o_ctrl) begin
      chk("ctrl_period", cyc - last_ctrl, CPH);
      last_ctrl = cyc;
      ctrl_idx++;
      chk("baud_phase", int'(o_baud), int'(ctrl_idx % 2 == 0));
    end else if (o_baud) begin
      chk("baud_no_ctrl", 1, 0);
    end
    if (o_baud && (o_state == 3'd2 || o_state == 3'd3)) begin
      chk("taps_sched", int'(o_en_taps), int'(bench_upd == UD - 1));
      bench_upd = (bench_upd == UD - 1) ? 0 : bench_upd + 1;
    end else if (o_en_taps) begin
      chk("taps_stray", 1, 0);
    end
  endtask

  task automatic run_to_cma(input bit do_reset);
    int n = 0;
    if (do_reset) begin
      i_reset = 1'b1; i_enable = 1'b0; i_force_dd = 1'b0; i_freeze = 1'b0;
      step(); step();
      i_reset = 1'b0;
    end
    i_enable = 1'b1;
    step();
    while (o_state != 3'd2 && n < 100) begin
      step();
      n++;
    end
    chk("fill_len", n, NT * CPH);
  endtask

  task automatic cma_timeout();
    int n = 0;
    int bauds = 0;
    int taps = 0;
    while (o_state != 3'd3 && n < 400) begin
      step();
      n++;
      if (o_baud) bauds++;
      if (o_en_taps) taps++;
    end
    chk("cma_len_cyc", n, 2 * CPH * CL - CPH);
    chk("cma_bauds", bauds, CL);
    chk("cma_taps", taps, CL / UD);
    chk("dd_mode", int'(o_mode), 1);
    for (int i = 0; i < 40; i++) step();
    chk("dd_state_kept", int'(o_state), 3);
  endtask

  vec_t tbl[17];

  initial begin
    int n, bauds, taps, ctrls, bad;
    int got, exp;

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 28, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);

    for (int i = 0; i < 17; i++) begin
      i_reset = tbl[i].rst; i_enable = tbl[i].en;
      i_force_dd = tbl[i].fdd; i_freeze = tbl[i].frz;
      for (int j = 0; j < tbl[i].ncyc; j++) step();
      got = int'({o_ctrl, o_baud, o_en_taps, o_mode, o_en_rx, o_state});
      exp = int'({tbl[i].ctrl, tbl[i].baud, tbl[i].taps, tbl[i].mode, tbl[i].en_rx, tbl[i].st});
      chk($sformatf("vec%0d", i), got, exp);
    end

    // CMA timeout into DD.
    run_to_cma(1'b1);
    cma_timeout();

    // Force DD one cycle after the 3rd CMA symbol.
    run_to_cma(1'b1);
    n = 0; bauds = 0;
    while (bauds < 3 && n < 100) begin
      step();
      n++;
      if (o_baud) bauds++;
    end
    chk("third_symbol", bauds, 3);
    i_force_dd = 1'b1;
    step();
    chk("force_state", int'(o_state), 3);
    chk("force_mode", int'(o_mode), 1);
    i_force_dd = 1'b0;
    bauds = 0; taps = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (o_baud) bauds++;
      if (o_en_taps) taps++;
      if (o_state != 3'd3) bad++;
    end
    chk("force_dd_stays", bad, 0);
    chk("force_bauds", bauds, 25);
    chk("force_taps", taps, 13);

    // Freeze held 40 cycles in DD, then release.
    i_freeze = 1'b1;
    taps = 0; ctrls = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_en_taps) taps++;
      if (o_ctrl) ctrls++;
      if (o_state != 3'd4 || !o_mode) bad++;
    end
    chk("hold_state_mode", bad, 0);
    chk("hold_taps", taps, 0);
    chk("hold_ctrls", ctrls, 10);
    i_freeze = 1'b0;
    step();
    chk("unfreeze_state", int'(o_state), 3);
    taps = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_en_taps) taps++;
    end
    chk("resume_taps", int'(taps >= 2 && taps <= 3), 1);

    // Freeze and force DD in the same CMA cycle.
    run_to_cma(1'b1);
    step(); step(); step();
    i_freeze = 1'b1; i_force_dd = 1'b1;
    step();
    chk("simul_state", int'(o_state), 4);
    chk("simul_mode", int'(o_mode), 1);
    i_force_dd = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("simul_hold", int'({o_mode, o_state}), int'({1'b1, 3'd4}));
    i_freeze = 1'b0;
    step();
    chk("simul_release", int'({o_mode, o_state}), int'({1'b1, 3'd3}));

    // Enable drop mid-CMA, restart from FILL with a fresh symbol count, then reset in DD.
    run_to_cma(1'b1);
    for (int i = 0; i < 30; i++) step();
    i_enable = 1'b0;
    step();
    chk("disable_outs", int'({o_en_rx, o_ctrl, o_baud, o_en_taps, o_mode, o_state}), 0);
    step(); step();
    run_to_cma(1'b0);
    cma_timeout();
    i_reset = 1'b1;
    step();
    chk("reset_in_dd", int'({o_en_rx, o_ctrl, o_baud, o_en_taps, o_mode, o_state}), 0);
    i_reset = 1'b0;
    step();
    chk("after_reset_fill", int'({o_en_rx, o_state}), int'({1'b1, 3'd1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
